// File: rtl/serial_pkg.sv
// Shared definitions for the serial line: FSM state type and line levels.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Kept separate so a future receiver can decode the same frame format.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Line levels for the framing bits.
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Per-bit timer: counts CLKS_PER_BIT enabled cycles and flags the last one.
// Latency: tick is combinational from the count; the count advances one per enabled cycle.
// Backpressure: en = 0 freezes the count; clear forces it back to zero.
//
// Ports: clk, reset (async active-low), en (stall when low),
//        clear (restart the bit), tick (high in the last cycle of a bit).
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wraps from LAST straight to zero so the count never reaches CLKS_PER_BIT.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_W bits LSB first, optional even parity, stop bit.
// Latency: first start-bit cycle follows the accept edge; frame is (DATA_W+2|3)*CLKS_PER_BIT cycles.
// Backpressure: ready only in IDLE with en = 1; valid/data_in ignored while busy; en = 0 stalls everything.
//
// Ports: clk, reset (async active-low), en, data_in[DATA_W], valid  -> inputs
//        ready, tx (idle high), busy, done (one-cycle pulse)        -> outputs
// Build option: define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic              done_q,  done_d;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic accept;
    logic tick;
    logic step;
    logic timer_clear;

    // Gating with reset keeps ready low while reset is held even though the
    // state register already reads IDLE.
    assign ready  = reset && en && (state_q == IDLE);
    assign accept = valid && ready;
    assign step   = en && tick;
    assign busy   = (state_q != IDLE);
    // done_q is held during a stall but only shown on an enabled cycle, so a
    // stall can neither stretch nor duplicate the pulse.
    assign done   = done_q && en;

    // Timer idles at zero and restarts on accept so the start bit is full length.
    assign timer_clear = (state_q == IDLE) || accept;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clear (timer_clear),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        done_d   = done_q;
`ifdef SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (en) begin
            done_d = 1'b0;
        end

        if (accept) begin
            state_d  = START;
            shift_d  = data_in;
            idx_d    = '0;
`ifdef SERIAL_TX_PARITY_EN
            parity_d = ^data_in;
`endif
        end else if (step) begin
            case (state_q)
                START: begin
                    state_d = DATA;
                end
                DATA: begin
                    if (idx_q == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    state_d = STOP;
                end
`endif
                STOP: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Line driver is purely a function of state so reset forces idle level at once.
    always_comb begin
        tx = LINE_IDLE;
        case (state_q)
            START:  tx = LINE_START;
            DATA:   tx = shift_q[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY: tx = parity_q;
`endif
            STOP:   tx = LINE_STOP;
            default: tx = LINE_IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx (DATA_W=8, CLKS_PER_BIT=4).
module tb_serial_tx;

    localparam int CPB = 4;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] data_in;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    serial_tx #(
        .DATA_W       (8),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .data_in (data_in),
        .valid   (valid),
        .ready   (ready),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word and return just after the accept edge.
    task automatic send(input logic [7:0] d);
        data_in = d;
        valid   = 1'b1;
        en      = 1'b1;
        #1;
        for (int i = 0; i < 100 && ready !== 1'b1; i++) tick();
        check("ready_to_accept", ready, 1);
        tick();
        valid = 1'b0;
    endtask

    // Called just after the accept edge. Walks the whole frame, optionally
    // stalling en for stall_len cycles starting at cycle stall_at, and ends
    // on the done cycle.
    task automatic run_frame(input logic [7:0] d, input int stall_at, input int stall_len);
        logic [15:0] exp_bits;
        logic [15:0] got_bits;
        int nbits;
        int total;
        int en_cnt;
        int bad;
        int k;
        exp_bits      = '0;
        got_bits      = '0;
        exp_bits[0]   = 1'b0;
        exp_bits[8:1] = d;
`ifdef SERIAL_TX_PARITY_EN
        exp_bits[9]   = ^d;
        exp_bits[10]  = 1'b1;
        nbits         = 11;
`else
        exp_bits[9]   = 1'b1;
        nbits         = 10;
`endif
        total  = nbits * CPB + stall_len;
        en_cnt = 0;
        bad    = 0;
        for (int c = 0; c < total; c++) begin
            en = !(c >= stall_at && c < stall_at + stall_len);
            #1;
            k = en_cnt / CPB;
            if (tx !== exp_bits[k] || busy !== 1'b1 || done !== 1'b0 || ready !== 1'b0)
                bad++;
            if (en_cnt % CPB == 0)
                got_bits[k] = tx;
            if (en)
                en_cnt++;
            tick();
        end
        en = 1'b1;
        #1;
        check("frame_bits", got_bits, exp_bits);
        check("frame_hold", bad, 0);
        check("done_at_end", done, 1);
        check("ready_at_done", ready, 1);
        check("busy_at_done", busy, 0);
        check("tx_idle_at_done", tx, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        // Power-up: reset held low with a word already offered.
        reset   = 1'b0;
        en      = 1'b1;
        valid   = 1'b1;
        data_in = 8'h55;
        #1;
        check("rst_tx", tx, 1);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        tick(); tick(); tick();
        check("rst_ready_clk", ready, 0);
        check("rst_busy_clk", busy, 0);

        // Release reset with en low: still no accept.
        en    = 1'b0;
        reset = 1'b1;
        tick(); tick();
        check("no_accept_en0_busy", busy, 0);
        check("no_accept_en0_ready", ready, 0);
        en = 1'b1;
        #1;
        check("ready_first_en", ready, 1);
        tick();
        valid = 1'b0;
        run_frame(8'h55, -1, 0);
        tick();
        check("done_one_cycle", done, 0);

        // Single frame; data_in changing after accept must not matter.
        send(8'hA5);
        data_in = 8'hFF;
        run_frame(8'hA5, -1, 0);

        // Frame whose parity bit is 1 when parity is built in.
        send(8'h01);
        run_frame(8'h01, -1, 0);

        // Stall for 7 cycles in the middle of data bit 1.
        send(8'hA5);
        run_frame(8'hA5, 9, 7);

        // Back-to-back with valid held high throughout.
        data_in = 8'h3C;
        valid   = 1'b1;
        #1;
        for (int i = 0; i < 100 && ready !== 1'b1; i++) tick();
        check("b2b_ready", ready, 1);
        tick();
        data_in = 8'hC3;
        run_frame(8'h3C, -1, 0);
        tick();
        valid = 1'b0;
        run_frame(8'hC3, -1, 0);
        tick();
        check("b2b_done_one_cycle", done, 0);

        // Reset in the middle of a frame (data bit 3 of 8'h96 is 0).
        send(8'h96);
        for (int i = 0; i < 17; i++) tick();
        check("pre_reset_tx", tx, 0);
        reset = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_ready", ready, 0);
        tick(); tick();
        reset = 1'b1;
        #1;
        check("post_rst_ready", ready, 1);
        send(8'h5A);
        run_frame(8'h5A, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
